dma_int_event_arbiter: RTL and testbench

- Shares one interrupt-X status queue write port between NUM_REQ descriptor-completion sources. Sources are DMA channel engines or stream engines.
- Each source offers one 42-bit status event: {extDscrptrAddr[31:0], dscrptrNum[5:0], inValidDscrptr, rdError, wrError, opDone}.
- The block picks a source by round-robin, with optional error-first priority. It registers the event into a one-entry output stage and writes it to the queue when the queue is not full.
- It sits between the channel engines and the interrupt-X controller's FIFO write side (valid/dataIn).

---
 rtl/dma_int_event_arbiter.sv | 113 +++++++++++
 tb/tb_dma_int_event_arbiter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/dma_int_event_arbiter.sv
// Round-robin arbiter that funnels per-source DMA completion events into one
// interrupt status queue write port through a single-entry output stage.
module dma_int_event_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int DATA_W       = 42,
    parameter int ERR_PRIORITY = 1
) (
    input  logic                      clock,
    input  logic                      resetn,
    input  logic                      arbEn,
    input  logic [NUM_REQ-1:0]        reqValid,
    input  logic [NUM_REQ*DATA_W-1:0] reqData,
    output logic [NUM_REQ-1:0]        reqReady,
    input  logic                      queueFull,
    output logic                      queueWrEn,
    output logic [DATA_W-1:0]         queueWrData,
    output logic [2:0]                lastGrant,
    output logic                      stageValid
);

    localparam logic [2:0] LAST_IDX = 3'(NUM_REQ - 1);

    logic                stage_valid_q, stage_valid_d;
    logic [DATA_W-1:0]   stage_data_q,  stage_data_d;
    logic [2:0]          last_grant_q,  last_grant_d;
    logic [2:0]          rr_ptr_q,      rr_ptr_d;

    logic [NUM_REQ-1:0]  err_mask;
    logic [NUM_REQ-1:0]  cand_mask;
    logic [2:0]          winner;
    logic [DATA_W-1:0]   winner_data;
    logic                stage_free;
    logic                queue_wr;
    logic                accept;

    // Sources reporting wrError, rdError or inValidDscrptr.
    always_comb begin
        err_mask = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            err_mask[i] = reqValid[i] & (|reqData[i*DATA_W+1 +: 3]);
        end
    end

    assign cand_mask = ((ERR_PRIORITY != 0) && (|err_mask)) ? err_mask : reqValid;

    // First candidate at or after rr_ptr_q, wrapping at NUM_REQ.
    always_comb begin
        logic found;
        int   idx;
        found       = 1'b0;
        idx         = 0;
        winner      = '0;
        winner_data = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!found && cand_mask[idx]) begin
                found       = 1'b1;
                winner      = 3'(idx);
                winner_data = reqData[idx*DATA_W +: DATA_W];
            end
        end
    end

    assign queue_wr   = stage_valid_q & ~queueFull;
    assign stage_free = ~stage_valid_q | ~queueFull;
    assign accept     = arbEn & stage_free & (|reqValid);

    always_comb begin
        reqReady = '0;
        if (accept) begin
            reqReady = {{(NUM_REQ-1){1'b0}}, 1'b1} << winner;
        end
    end

    always_comb begin
        stage_valid_d = stage_valid_q;
        stage_data_d  = stage_data_q;
        last_grant_d  = last_grant_q;
        rr_ptr_d      = rr_ptr_q;
        if (accept) begin
            // A write in the same cycle frees the slot, so the new event simply replaces it.
            stage_valid_d = 1'b1;
            stage_data_d  = winner_data;
            last_grant_d  = winner;
            rr_ptr_d      = (winner == LAST_IDX) ? 3'd0 : winner + 3'd1;
        end else if (queue_wr) begin
            stage_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            stage_valid_q <= 1'b0;
            stage_data_q  <= '0;
            last_grant_q  <= LAST_IDX;
            rr_ptr_q      <= 3'd0;
        end else begin
            stage_valid_q <= stage_valid_d;
            stage_data_q  <= stage_data_d;
            last_grant_q  <= last_grant_d;
            rr_ptr_q      <= rr_ptr_d;
        end
    end

    assign queueWrEn   = queue_wr;
    assign queueWrData = stage_data_q;
    assign lastGrant   = last_grant_q;
    assign stageValid  = stage_valid_q;

endmodule

// File: tb/tb_dma_int_event_arbiter.sv
// Directed bench for dma_int_event_arbiter: one instance with error-first
// priority and one with plain round-robin, driven from shared stimulus.
module tb_dma_int_event_arbiter;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 42;

    logic                      clock = 1'b0;
    logic                      resetn;
    logic                      arbEn;
    logic [NUM_REQ-1:0]        reqValid;
    logic [NUM_REQ*DATA_W-1:0] reqData;
    logic                      queueFull;

    logic [NUM_REQ-1:0] ready_e,  ready_n;
    logic               wren_e,   wren_n;
    logic [DATA_W-1:0]  wrdata_e, wrdata_n;
    logic [2:0]         last_e,   last_n;
    logic               sv_e,     sv_n;

    logic [DATA_W-1:0] src_d [NUM_REQ];
    logic [DATA_W-1:0] err0;
    logic [DATA_W-1:0] beef;

    int n_checks = 0;
    int n_errors = 0;

    assign reqData = {src_d[3], src_d[2], src_d[1], src_d[0]};

    always #5 clock = ~clock;

    dma_int_event_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ERR_PRIORITY(1)) u_dut_err (
        .clock(clock), .resetn(resetn), .arbEn(arbEn), .reqValid(reqValid), .reqData(reqData),
        .reqReady(ready_e), .queueFull(queueFull), .queueWrEn(wren_e), .queueWrData(wrdata_e),
        .lastGrant(last_e), .stageValid(sv_e)
    );

    dma_int_event_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ERR_PRIORITY(0)) u_dut_rr (
        .clock(clock), .resetn(resetn), .arbEn(arbEn), .reqValid(reqValid), .reqData(reqData),
        .reqReady(ready_n), .queueFull(queueFull), .queueWrEn(wren_n), .queueWrData(wrdata_n),
        .lastGrant(last_n), .stageValid(sv_n)
    );

    function automatic logic [DATA_W-1:0] mk(input logic [31:0] addr, input logic [5:0] num,
                                             input logic [3:0] flags);
        return {addr, num, flags};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        resetn    = 1'b0;
        arbEn     = 1'b0;
        reqValid  = '0;
        queueFull = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            src_d[i] = mk(32'h1000_00A0 + 32'(i), 6'(i + 1), 4'b0001);
        end
        err0 = mk(32'h1000_00A0, 6'd1, 4'b0100);
        beef = 42'h37A_B6FB_BE01;

        // Reset state
        repeat (2) @(negedge clock);
        #1;
        chk("rst_stage_valid", 64'(sv_e), 64'(0));
        chk("rst_wren", 64'(wren_e), 64'(0));
        chk("rst_wrdata", 64'(wrdata_e), 64'(0));
        chk("rst_last_grant", 64'(last_e), 64'(3));
        chk("rst_last_grant_rr", 64'(last_n), 64'(3));
        chk("rst_ready", 64'(ready_e), 64'(0));

        // All four sources valid: strict rotation, writes trail by one cycle
        @(negedge clock);
        resetn   = 1'b1;
        arbEn    = 1'b1;
        reqValid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("rot_ready", 64'(ready_e), 64'(4'b0001 << (k % 4)));
            chk("rot_wren", 64'(wren_e), 64'(k > 0));
            if (k > 0) begin
                chk("rot_wrdata", 64'(wrdata_e), 64'(src_d[(k - 1) % 4]));
            end
            @(negedge clock);
        end
        reqValid = '0;
        #1;
        chk("drain_wren", 64'(wren_e), 64'(1));
        chk("drain_wrdata", 64'(wrdata_e), 64'(src_d[0]));
        chk("drain_ready", 64'(ready_e), 64'(0));
        @(negedge clock);
        #1;
        chk("drain_empty", 64'(sv_e), 64'(0));
        chk("drain_empty_wren", 64'(wren_e), 64'(0));

        // Move rrPtr to 2, then error source 0 against source 3
        reqValid = 4'b0010;
        #1;
        chk("pre_err_ready", 64'(ready_e), 64'(4'b0010));
        chk("pre_err_ready_rr", 64'(ready_n), 64'(4'b0010));
        @(negedge clock);
        src_d[0] = err0;
        reqValid = 4'b1011;
        #1;
        chk("err_first_ready", 64'(ready_e), 64'(4'b0001));
        chk("rr_only_ready", 64'(ready_n), 64'(4'b1000));
        chk("err_wrdata_prev", 64'(wrdata_e), 64'(src_d[1]));
        @(negedge clock);
        src_d[0] = mk(32'h1000_00A0, 6'd1, 4'b0001);
        reqValid = 4'b1111;
        #1;
        chk("err_last_grant", 64'(last_e), 64'(0));
        chk("rr_last_grant", 64'(last_n), 64'(3));
        chk("err_wrdata", 64'(wrdata_e), 64'(err0));
        chk("rr_wrdata", 64'(wrdata_n), 64'(src_d[3]));
        chk("err_rrptr_after", 64'(ready_e), 64'(4'b0010));
        chk("rr_wrap_after", 64'(ready_n), 64'(4'b0001));
        @(negedge clock);
        reqValid = '0;
        #1;
        chk("err_last_grant2", 64'(last_e), 64'(1));
        chk("rr_last_grant2", 64'(last_n), 64'(0));
        @(negedge clock);
        #1;
        chk("err_drained", 64'(sv_e), 64'(0));

        // Queue full with a loaded stage
        reqValid = 4'b0001;
        #1;
        chk("full_load_ready", 64'(ready_e), 64'(4'b0001));
        @(negedge clock);
        reqValid  = 4'b0110;
        queueFull = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("full_wren", 64'(wren_e), 64'(0));
            chk("full_ready", 64'(ready_e), 64'(0));
            chk("full_wrdata", 64'(wrdata_e), 64'(src_d[0]));
            chk("full_stage_valid", 64'(sv_e), 64'(1));
            @(negedge clock);
        end
        queueFull = 1'b0;
        #1;
        chk("unfull_wren", 64'(wren_e), 64'(1));
        chk("unfull_wrdata", 64'(wrdata_e), 64'(src_d[0]));
        chk("unfull_ready", 64'(ready_e), 64'(4'b0010));
        chk("unfull_ready_rr", 64'(ready_n), 64'(4'b0010));
        @(negedge clock);
        reqValid = '0;
        #1;
        chk("unfull_wrdata2", 64'(wrdata_e), 64'(src_d[1]));
        chk("unfull_last", 64'(last_e), 64'(1));
        @(negedge clock);
        #1;
        chk("unfull_empty", 64'(sv_e), 64'(0));

        // arbEn dropped with the stage loaded
        reqValid = 4'b1111;
        #1;
        chk("en_load_ready", 64'(ready_e), 64'(4'b0100));
        @(negedge clock);
        arbEn = 1'b0;
        #1;
        chk("dis_ready", 64'(ready_e), 64'(0));
        chk("dis_wren", 64'(wren_e), 64'(1));
        chk("dis_wrdata", 64'(wrdata_e), 64'(src_d[2]));
        @(negedge clock);
        #1;
        chk("dis_empty", 64'(sv_e), 64'(0));
        chk("dis_wren2", 64'(wren_e), 64'(0));
        chk("dis_ready2", 64'(ready_e), 64'(0));
        @(negedge clock);
        #1;
        chk("dis_ready3", 64'(ready_e), 64'(0));
        arbEn = 1'b1;
        #1;
        chk("reen_ready", 64'(ready_e), 64'(4'b1000));
        @(negedge clock);
        reqValid  = '0;
        queueFull = 1'b1;
        #1;
        chk("blk_stage_valid", 64'(sv_e), 64'(1));
        chk("blk_wrdata", 64'(wrdata_e), 64'(src_d[3]));

        // Reset mid-stream while blocked
        resetn = 1'b0;
        #1;
        chk("mid_rst_stage_valid", 64'(sv_e), 64'(0));
        chk("mid_rst_wren", 64'(wren_e), 64'(0));
        chk("mid_rst_last", 64'(last_e), 64'(3));
        chk("mid_rst_wrdata", 64'(wrdata_e), 64'(0));
        repeat (2) @(negedge clock);
        resetn    = 1'b1;
        queueFull = 1'b0;
        reqValid  = 4'b1111;
        #1;
        chk("post_rst_ready", 64'(ready_e), 64'(4'b0001));

        // Single continuous requester: source 2
        @(negedge clock);
        src_d[2] = mk(32'hDEAD_BEEF, 6'd32, 4'b0001);
        reqValid = 4'b0100;
        #1;
        chk("single_ready0", 64'(ready_e), 64'(4'b0100));
        chk("single_wrdata0", 64'(wrdata_e), 64'(src_d[0]));
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            #1;
            chk("single_ready", 64'(ready_e), 64'(4'b0100));
            chk("single_wren", 64'(wren_e), 64'(1));
            chk("single_wrdata", 64'(wrdata_e), 64'(beef));
            chk("single_last", 64'(last_e), 64'(2));
        end
        @(negedge clock);
        reqValid = '0;
        @(negedge clock);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
